// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Round-robin arbiter and sequencer for one shared down-counter.
//               Each requester asks for a timed interval of its own length.
//               The winner is granted the counter, which is loaded with that
//               requester's length and counted down. The winner then receives
//               a one-cycle done pulse.
// Ports       : clk     - clock, all logic on the rising edge
//               rst     - synchronous active-high reset
//               req_i   - per-requester level request
//               len_i   - packed lengths, requester i at [i*CNT_W +: CNT_W]
//               hold_i  - freezes the counter while counting
//               gnt_o   - registered one-hot grant
//               done_o  - registered one-cycle completion pulse
//               busy_o  - high whenever the sequencer is not idle
//               cnt_o   - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*CNT_W-1:0] len_i,
    input  logic                   hold_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       cnt_o
);

    localparam int               PTR_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT_LSB  = N_REQ'(1);
    localparam logic [PTR_W-1:0] LAST_IDX     = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_REQ_WIDE   = (PTR_W + 1)'(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   idx_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               w_found;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_winner;
    logic [CNT_W-1:0]   w_len_win;
    logic [PTR_W-1:0]   w_ptr_next;

    // Round-robin search: scan upward from ptr_q and wrap modulo N_REQ.
    // The sum is one bit wider so the wrap also works for non power-of-two
    // requester counts.
    always_comb begin
        w_found  = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        w_winner = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (w_sum >= N_REQ_WIDE) begin
                w_sum = w_sum - N_REQ_WIDE;
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!w_found && req_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Length mux with constant slice bounds only.
    always_comb begin
        w_len_win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winner == PTR_W'(k)) begin
                w_len_win = len_i[k*CNT_W +: CNT_W];
            end
        end
    end

    // The pointer moves to the requester just past the one last served.
    assign w_ptr_next = (idx_q == LAST_IDX) ? '0 : idx_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= '0;
                    if (w_found) begin
                        state_q <= ST_COUNT;
                        idx_q   <= w_winner;
                        gnt_q   <= ONE_HOT_LSB << w_winner;
                        cnt_q   <= w_len_win;
                    end
                end
                ST_COUNT: begin
                    // Withdrawal beats both hold and reaching zero.
                    if (!req_i[idx_q]) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        ptr_q   <= w_ptr_next;
                    end else if (hold_i) begin
                        cnt_q <= cnt_q;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        // The grant is one-hot on the winner, so it doubles as the done mask.
                        done_q  <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    ptr_q   <= w_ptr_next;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign busy_o = (state_q != ST_IDLE);
    assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin arbiter and sequencer for a single shared down-counter, built from the team's counter primitives. Up to `N_REQ` requesters each ask for a timed interval of a programmable length. The block grants the counter to one requester at a time, loads that requester's length, and counts it down. It then pulses that requester's `done`. It sits between the counter datapath and any logic that needs cycle-accurate delays (debounce, pulse stretch, wait states).

## Interface
- `N_REQ`, default 4: number of requesters (≥2).
- `CNT_W`, default 4: counter width; maximum interval length is 2^CNT_W−1.

- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N_REQ: per-requester level request.
- `len` input N_REQ*CNT_W: packed lengths; requester i uses `len[i*CNT_W +: CNT_W]`.
- `hold` input 1: freezes the counter while high in COUNT.
- `gnt` output N_REQ: one-hot grant, registered.
- `done` output N_REQ: one-cycle completion pulse, registered.
- `busy` output 1: high when state ≠ IDLE.
- `cnt` output CNT_W: current counter value.

## Operation
- The FSM has 3 states: IDLE, COUNT, DONE. Reset state is IDLE.
- **IDLE:**
  - If any `req` bit is high, select winner i by round-robin, searching upward from `ptr` with wrap.
  - Next cycle: `gnt`=onehot(i), `cnt`=`len[i]` (latched), state COUNT.
  - If no `req` bit is high, stay in IDLE.
- **COUNT:**
  - If `req[i]`=0 (withdrawal), go to IDLE next cycle. No `done` pulse. `gnt` and `cnt` clear to 0. `ptr` = (i+1) mod N_REQ.
  - Else if `hold`=1, hold `cnt`.
  - Else if `cnt`=0, go to DONE.
  - Else decrement `cnt` by 1.
  - Withdrawal has priority over `hold` and over reaching zero.
- **DONE:**
  - `done[i]`=1 and `gnt[i]` stays 1 for this one cycle.
  - Next cycle: IDLE, `gnt`=0, `done`=0, `ptr`=(i+1) mod N_REQ.
  - `req[i]` is ignored in this state.
- `len` and non-granted `req` bits are ignored after the load.
- A requester that keeps `req` high after `done` is treated as a new request. It competes in the next IDLE at lowest priority because `ptr` has moved past it.
- `cnt` never wraps. Decrement happens only when `cnt`>0.
- `ptr` resets to 0. `ptr` updates only on DONE exit or on withdrawal.

## Timing
- Reset values: `gnt`=0, `done`=0, `busy`=0, `cnt`=0, `ptr`=0, state IDLE.
- `rst` has priority over everything. If asserted mid-COUNT or mid-DONE, all outputs are 0 the next cycle and no `done` is issued.
- Latency, with `req` sampled high in IDLE at cycle T, length L, and no `hold`:
  - `gnt` and `busy` rise at T+1, with `cnt`=L.
  - `cnt` reaches 0 at T+1+L.
  - `done` pulses at T+2+L.
  - `gnt` falls at T+3+L.
- Each active `hold` cycle adds exactly one cycle to the latency.
- L=0: `gnt` at T+1, `done` at T+2.
- Back-to-back service period is L+3 cycles: the grant lasts L+2 cycles and one IDLE cycle follows.
- `gnt` is always one-hot or zero. `done` is always a subset of `gnt`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0, `done`=0, `busy`=0, `cnt`=0. First grant after release goes to requester 0.
- Single request: `req`=0001, `len0`=5 at cycle 0 → `gnt`=0001 at cycle 1 with `cnt`=5, `cnt`=0 at cycle 6, `done`=0001 at cycle 7, `gnt`=0 at cycle 8.
- Zero length: `req`=0100, `len2`=0 → `gnt`=0100 at cycle 1, `done`=0100 at cycle 2, `busy`=0 at cycle 3.
- Fairness: `req`=1111 held, all `len`=2 → grant order 0,1,2,3,0. Each grant lasts 4 cycles. Grant starts are 5 cycles apart, at cycles 1, 6, 11, 16, 21.
- Withdrawal and hold:
  - With `len0`=7, drop `req[0]` when `cnt`=3 → next cycle IDLE, no `done`; next grant goes to requester 1 if it is requesting.
  - Separately, with `len`=4, assert `hold` for 3 cycles during COUNT → `done` arrives 3 cycles later than nominal (cycle 9 instead of 6).
- Reset mid-count: `len1`=9, assert `rst` at `cnt`=4 → next cycle all outputs 0, no `done[1]` ever; `ptr`=0.
